// File: rtl/fft_pkg.sv
// ============================================================================
// fft_pkg : shared state encoding and index helpers for the FFT bank control
// Rev 1.0 | optional FFT_BANK_CTRL_BITREV_EN adds the OUTPUT state
// ============================================================================
`default_nettype none

package fft_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
`ifdef FFT_BANK_CTRL_BITREV_EN
    , ST_OUTPUT = 3'd5
`endif
  } fft_state_t;

  // Bank holding an element: parity of its index bits
  function automatic logic fft_bank(input logic [31:0] idx);
    return ^idx;
  endfunction

  // Reverse the low w bits of v
  function automatic logic [31:0] fft_bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < w) r = {r[30:0], v[b]};
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_addr_gen.sv
// ============================================================================
// fft_addr_gen : butterfly operand index, bank and twiddle address generation
// Rev 1.0 | combinational, driven by stage and butterfly counters
// ============================================================================
`default_nettype none

module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int R  = 5,
  parameter int SW = 3
) (
  input  logic [SW-1:0] i_stage,
  input  logic [R-2:0]  i_k,
  output logic [R-2:0]  o_addr0,
  output logic [R-2:0]  o_addr1,
  output logic [R-2:0]  o_tw_addr,
  output logic          o_swap
);

  logic [R-1:0] w_k;
  logic [R-1:0] w_bit;
  logic [R-1:0] w_mask;
  logic [R-1:0] w_lower;
  logic [R-1:0] w_upper;
  logic         w_swap;

  // w_bit marks position p = R-1-stage where the 0/1 is inserted
  assign w_k     = {1'b0, i_k};
  assign w_bit   = R'(1) << (R - 1 - int'(i_stage));
  assign w_mask  = w_bit - R'(1);
  assign w_lower = ((w_k & ~w_mask) << 1) | (w_k & w_mask);
  assign w_upper = w_lower | w_bit;
  assign w_swap  = fft_bank(32'(w_lower));

  assign o_swap    = w_swap;
  assign o_addr0   = w_swap ? w_upper[R-1:1] : w_lower[R-1:1];
  assign o_addr1   = w_swap ? w_lower[R-1:1] : w_upper[R-1:1];
  assign o_tw_addr = (i_k & w_mask[R-2:0]) << i_stage;

endmodule

`default_nettype wire

// File: rtl/fft_bank_ctrl.sv
// ============================================================================
// fft_bank_ctrl : in-place radix-2 DIF FFT sequencer over two memory banks
// Rev 1.0 | define FFT_BANK_CTRL_BITREV_EN for bit-reversed OUTPUT readout
// ============================================================================
`default_nettype none

module fft_bank_ctrl
  import fft_pkg::*;
#(
  parameter int R      = 5,
  parameter int BF_LAT = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [$clog2(R)-1:0] o_stage,
  output logic [R-2:0]         o_addr0,
  output logic [R-2:0]         o_addr1,
  output logic                 o_w_en0,
  output logic                 o_w_en1,
  output logic                 o_swap,
  output logic [R-2:0]         o_tw_addr,
`ifdef FFT_BANK_CTRL_BITREV_EN
  output logic                 o_out_valid,
  output logic                 o_out_bank,
`endif
  output logic                 o_bf_valid
);

  localparam int SW = $clog2(R);

  fft_state_t    r_state;
  fft_state_t    w_next;
  logic [SW-1:0] r_s;
  logic [R-2:0]  r_k;
  logic [3:0]    r_wcnt;
  logic          w_k_last;
  logic          w_s_last;
  logic          w_wait_last;
  logic [R-2:0]  w_ga0;
  logic [R-2:0]  w_ga1;
  logic [R-2:0]  w_gtw;
  logic          w_gswap;

  assign w_k_last    = &r_k;
  assign w_s_last    = (r_s == SW'(R - 1));
  assign w_wait_last = (r_wcnt == 4'(BF_LAT - 1));
  assign o_stage     = r_s;

  fft_addr_gen #(.R(R), .SW(SW)) u_addr_gen (
    .i_stage   (r_s),
    .i_k       (r_k),
    .o_addr0   (w_ga0),
    .o_addr1   (w_ga1),
    .o_tw_addr (w_gtw),
    .o_swap    (w_gswap)
  );

`ifdef FFT_BANK_CTRL_BITREV_EN
  logic [R-1:0] r_m;
  logic [R-1:0] w_ridx;
  logic         w_rbank;
  logic         r_out_valid;
  logic         r_out_bank;

  assign w_ridx      = R'(fft_bitrev(32'(r_m), R));
  assign w_rbank     = fft_bank(32'(w_ridx));
  assign o_out_valid = r_out_valid;
  assign o_out_bank  = r_out_bank;

  // Readout data appears one cycle after the bank read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_m         <= '0;
      r_out_valid <= 1'b0;
      r_out_bank  <= 1'b0;
    end else begin
      r_out_valid <= (r_state == ST_OUTPUT);
      r_out_bank  <= (r_state == ST_OUTPUT) && w_rbank;
      if (r_state == ST_OUTPUT) r_m <= r_m + R'(1);
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s    <= '0;
      r_k    <= '0;
      r_wcnt <= '0;
    end else begin
      r_wcnt <= (r_state == ST_WAIT) ? r_wcnt + 4'd1 : 4'd0;
      if (r_state == ST_WRITE) begin
        r_k <= r_k + (R-1)'(1);
        if (w_k_last) r_s <= w_s_last ? '0 : r_s + SW'(1);
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_addr0    = '0;
    o_addr1    = '0;
    o_w_en0    = 1'b0;
    o_w_en1    = 1'b0;
    o_swap     = 1'b0;
    o_tw_addr  = '0;
    o_bf_valid = 1'b0;
    case (r_state)
      ST_IDLE: if (i_start) w_next = ST_READ;
      ST_READ, ST_WAIT, ST_WRITE: begin
        o_busy    = 1'b1;
        o_addr0   = w_ga0;
        o_addr1   = w_ga1;
        o_swap    = w_gswap;
        o_tw_addr = w_gtw;
        if (r_state == ST_READ) begin
          w_next = ST_WAIT;
        end else if (r_state == ST_WAIT) begin
          o_bf_valid = (r_wcnt == 4'd0);
          if (w_wait_last) w_next = ST_WRITE;
        end else begin
          o_w_en0 = 1'b1;
          o_w_en1 = 1'b1;
          if (w_k_last && w_s_last) begin
`ifdef FFT_BANK_CTRL_BITREV_EN
            w_next = ST_OUTPUT;
`else
            w_next = ST_DONE;
`endif
          end else begin
            w_next = ST_READ;
          end
        end
      end
`ifdef FFT_BANK_CTRL_BITREV_EN
      ST_OUTPUT: begin
        o_busy = 1'b1;
        if (w_rbank) o_addr1 = w_ridx[R-1:1];
        else         o_addr0 = w_ridx[R-1:1];
        if (&r_m) w_next = ST_DONE;
      end
`endif
      ST_DONE: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_fft_bank_ctrl.sv
// ============================================================================
// tb_fft_bank_ctrl : randomized start/reset stimulus against a timeline model
// Rev 1.0 | define FFT_BANK_CTRL_BITREV_EN to also check the OUTPUT readout
// ============================================================================
`default_nettype none

module tb_fft_bank_ctrl;

  localparam int R      = 3;
  localparam int BF_LAT = 2;
  localparam int N      = 1 << R;
  localparam int NB     = R * N / 2;
  localparam int PER    = BF_LAT + 2;
`ifdef FFT_BANK_CTRL_BITREV_EN
  localparam int NOUT = N;
`else
  localparam int NOUT = 0;
`endif
  localparam int TL = NB * PER + NOUT + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 busy, done, w0, w1, swap, bfv;
  logic [$clog2(R)-1:0] stage;
  logic [R-2:0]         a0, a1, tw;
  logic                 ov, ob;

  always #5 clk = ~clk;

  fft_bank_ctrl #(.R(R), .BF_LAT(BF_LAT)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .o_busy     (busy),
    .o_done     (done),
    .o_stage    (stage),
    .o_addr0    (a0),
    .o_addr1    (a1),
    .o_w_en0    (w0),
    .o_w_en1    (w1),
    .o_swap     (swap),
    .o_tw_addr  (tw),
`ifdef FFT_BANK_CTRL_BITREV_EN
    .o_out_valid(ov),
    .o_out_bank (ob),
`endif
    .o_bf_valid (bfv)
  );

`ifndef FFT_BANK_CTRL_BITREV_EN
  assign ov = 1'b0;
  assign ob = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Expected per-cycle outputs from the cycle after start is accepted
  int e_busy[TL], e_done[TL], e_we[TL], e_bfv[TL], e_stg[TL], e_mode[TL];
  int e_a0[TL], e_a1[TL], e_swap[TL], e_tw[TL], e_ov[TL], e_ob[TL];
  int pos = -1;

  function automatic int brev(input int m);
    int r = 0;
    for (int b = 0; b < R; b++) r = (r << 1) | ((m >> b) & 1);
    return r;
  endfunction

  task automatic build_tl();
    int off = 0;
    for (int t = 0; t < TL; t++) begin
      e_busy[t] = 0; e_done[t] = 0; e_we[t] = 0; e_bfv[t] = 0; e_stg[t] = -1;
      e_mode[t] = 0; e_a0[t] = 0; e_a1[t] = 0; e_swap[t] = 0; e_tw[t] = 0;
      e_ov[t] = 0; e_ob[t] = 0;
    end
    for (int s = 0; s < R; s++) begin
      for (int k = 0; k < N / 2; k++) begin
        int p  = R - 1 - s;
        int lo = ((k >> p) << (p + 1)) + (k % (1 << p));
        int up = lo + (1 << p);
        int bl = $countones(lo) % 2;
        for (int c = 0; c < PER; c++) begin
          e_busy[off+c] = 1;
          e_stg[off+c]  = s;
          e_we[off+c]   = (c == PER - 1) ? 1 : 0;
          e_bfv[off+c]  = (c == 1) ? 1 : 0;
          if (c == 0 || c == PER - 1) begin
            e_mode[off+c] = 1;
            e_a0[off+c]   = bl ? (up >> 1) : (lo >> 1);
            e_a1[off+c]   = bl ? (lo >> 1) : (up >> 1);
            e_swap[off+c] = bl;
            e_tw[off+c]   = ((lo % (1 << p)) << s) % (N / 2);
          end
        end
        off += PER;
      end
    end
    for (int m = 0; m < NOUT; m++) begin
      int idx = brev(m);
      int bk  = $countones(idx) % 2;
      e_busy[off+m] = 1;
      e_mode[off+m] = 2;
      e_a0[off+m]   = bk ? 0 : (idx >> 1);
      e_a1[off+m]   = bk ? (idx >> 1) : 0;
      e_ov[off+m+1] = 1;
      e_ob[off+m+1] = bk;
    end
    off += NOUT;
    e_done[off] = 1;
    e_mode[off] = 1;
  endtask

  task automatic compare_now();
    string p = $sformatf("@%0d", pos);
    if (pos < 0) begin
      check_eq({"idle_busy", p}, busy, 0);
      check_eq({"idle_done", p}, done, 0);
      check_eq({"idle_wen", p}, {w0, w1}, 0);
      check_eq({"idle_bfv", p}, bfv, 0);
      check_eq({"idle_addr", p}, {a0, a1, tw, swap}, 0);
      check_eq({"idle_ov", p}, ov, 0);
    end else begin
      check_eq({"busy", p}, busy, e_busy[pos]);
      check_eq({"done", p}, done, e_done[pos]);
      check_eq({"wen0", p}, w0, e_we[pos]);
      check_eq({"wen1", p}, w1, e_we[pos]);
      check_eq({"bf_valid", p}, bfv, e_bfv[pos]);
      check_eq({"out_valid", p}, ov, e_ov[pos]);
      if (e_ov[pos] != 0) check_eq({"out_bank", p}, ob, e_ob[pos]);
      if (e_stg[pos] >= 0) check_eq({"stage", p}, stage, e_stg[pos]);
      if (e_mode[pos] != 0) begin
        check_eq({"addr0", p}, a0, e_a0[pos]);
        check_eq({"addr1", p}, a1, e_a1[pos]);
      end
      if (e_mode[pos] == 1) begin
        check_eq({"swap", p}, swap, e_swap[pos]);
        check_eq({"tw_addr", p}, tw, e_tw[pos]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) pos = -1;
    else if (pos < 0) begin
      if (start) pos = 0;
    end else begin
      pos++;
      if (pos == TL) pos = -1;
    end
    #1;
    compare_now();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, {busy, done, w0, w1, bfv, swap, ov, ob}, 0);
    check_eq({tag, "_addr"}, {a0, a1, tw}, 0);
    check_eq({tag, "_stage"}, stage, 0);
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock
  task automatic reset_mid();
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    pos = -1;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 4 * TL && pos != target; i++) step();
    if (pos != target) check_eq("run_to_timeout", pos, target);
  endtask

  initial begin
    build_tl();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("por");
    rst_n = 1'b1;

    // Sparse random starts with occasional mid-transform resets
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 3) == 0);
      step();
      if (pos > 0 && $urandom_range(0, 299) == 0) reset_mid();
    end

    // Start held high: one transform per IDLE entry
    start = 1'b1;
    repeat (3 * TL + 10) step();
    start = 1'b0;
    repeat (TL + 2) step();

    // Reset during the first stage-1 WAIT, then a clean restart
    start = 1'b1;
    step();
    start = 1'b0;
    run_to(PER * (N / 2) + 1);
    check_eq("s1_wait_stage", stage, 1);
    reset_mid();
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("restart_busy", busy, 1);
    check_eq("restart_addr0", a0, 0);
    check_eq("restart_addr1", a1, 2);
    check_eq("restart_swap", swap, 0);
    check_eq("restart_tw", tw, 0);
    step();
    check_eq("restart_bfv", bfv, 1);
    run_to(PER * (N / 2 + 1));
    check_eq("s1k1_addr0", a0, 1);
    check_eq("s1k1_addr1", a1, 0);
    check_eq("s1k1_swap", swap, 1);
    check_eq("s1k1_tw", tw, 2);
    run_to(TL - 1);
    check_eq("final_done", done, 1);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
